inst_seq_ctrl: RTL and testbench

Programmable sequencer that drives the field and select inputs of `inst_gen` from a small descriptor table. It issues a scripted instruction stream into the CPU fetch path under a valid/ready handshake, optionally looping. It sits between the testbench/host loader and `inst_gen`. `inst_gen`'s registered `inst` output pairs with this block's `inst_valid`.

---
 rtl/inst_seq_pkg.sv | 34 +++
 rtl/inst_seq_table.sv | 34 +++
 rtl/inst_seq_ctrl.sv | 173 +++++++++++++++++
 tb/tb_inst_seq_ctrl.sv | 231 +++++++++++++++++++++++
 4 files changed

// File: rtl/inst_seq_pkg.sv
// inst_seq_pkg: shared types and constants for the instruction sequencer.
//   state_t : sequencer FSM states
//   desc_t  : one descriptor table entry, DESC_W bits packed
//   SEL_*   : inst_gen format selector codes
package inst_seq_pkg;

  localparam int DESC_W = 42;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  // Field order matches the wr_data packing, most significant first.
  typedef struct packed {
    logic [3:0]  inst_sel;
    logic [2:0]  func3;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [4:0]  rd;
    logic [19:0] imm;
  } desc_t;

  localparam logic [3:0] SEL_R1 = 4'd1;
  localparam logic [3:0] SEL_R2 = 4'd2;
  localparam logic [3:0] SEL_I  = 4'd3;
  localparam logic [3:0] SEL_L  = 4'd4;
  localparam logic [3:0] SEL_S  = 4'd5;
  localparam logic [3:0] SEL_B  = 4'd6;
  localparam logic [3:0] SEL_U  = 4'd7;
  localparam logic [3:0] SEL_UJ = 4'd8;

endpackage

// File: rtl/inst_seq_table.sv
// inst_seq_table: DEPTH x DESC_W descriptor store.
//   clk     : write clock
//   wr_en   : write strobe (already qualified by the caller)
//   wr_addr : write index
//   wr_data : descriptor to store
//   rd_addr : combinational read index
//   rd_data : descriptor at rd_addr
// Contents are intentionally not reset: the loaded program survives rst.
module inst_seq_table
  import inst_seq_pkg::*;
#(
  parameter int DEPTH = 16,
  parameter int AW    = 4
) (
  input  logic          clk,
  input  logic          wr_en,
  input  logic [AW-1:0] wr_addr,
  input  desc_t         wr_data,
  input  logic [AW-1:0] rd_addr,
  output desc_t         rd_data
);

  desc_t mem [DEPTH];

  // Synchronous write port.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_addr] <= wr_data;
    end
  end

  assign rd_data = mem[rd_addr];

endmodule

// File: rtl/inst_seq_ctrl.sv
// inst_seq_ctrl: issues a scripted instruction stream from a descriptor
// table into inst_gen under a valid/ready handshake.
//   clk, rst          : clock, synchronous active-high reset
//   wr_en/addr/data   : table load port (ignored while busy)
//   start, len, loop  : run control, len/loop latched on start
//   abort             : stop the run without a done pulse
//   cpu_ready         : consumer accepts the current inst
//   inst_sel..immuj   : field outputs to inst_gen (table entry at nxt)
//   inst_valid        : inst_gen.inst holds an issued entry
//   busy, done        : RUN state, one-cycle completion pulse
//   issue_cnt         : saturating count of accepted instructions
module inst_seq_ctrl
  import inst_seq_pkg::*;
#(
  parameter int DEPTH = 16,
  parameter int AW    = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          wr_en,
  input  logic [AW-1:0] wr_addr,
  input  logic [41:0]   wr_data,
  input  logic          start,
  input  logic [AW:0]   len,
  input  logic          loop,
  input  logic          abort,
  input  logic          cpu_ready,
  output logic [3:0]    inst_sel,
  output logic [2:0]    func3,
  output logic [4:0]    rs1,
  output logic [4:0]    rs2,
  output logic [4:0]    rd,
  output logic [11:0]   immi,
  output logic [11:0]   imms,
  output logic [11:0]   immb,
  output logic [19:0]   immu,
  output logic [19:0]   immuj,
  output logic          inst_valid,
  output logic          busy,
  output logic          done,
  output logic [15:0]   issue_cnt
);

  localparam int unsigned LW = AW + 1;
  localparam logic [AW:0] DEPTH_L = LW'(DEPTH);

  state_t        state, state_nxt;
  logic [AW-1:0] cur, nxt;
  logic [AW:0]   len_q, len_clamp;
  logic          loop_q;
  logic          valid_nxt;
  logic          fire, last;
  desc_t         rd_desc, field;

  assign len_clamp = (len > DEPTH_L) ? DEPTH_L : len;
  assign fire      = inst_valid & cpu_ready;
  assign last      = ({1'b0, cur} == (len_q - {{AW{1'b0}}, 1'b1}));

  inst_seq_table #(.DEPTH(DEPTH), .AW(AW)) u_table (
    .clk     (clk),
    .wr_en   (wr_en & (state != RUN)),
    .wr_addr (wr_addr),
    .wr_data (wr_data),
    .rd_addr (nxt),
    .rd_data (rd_desc)
  );

  // Next-state, next-index and next-valid decode.
  always_comb begin
    state_nxt = state;
    nxt       = cur;
    valid_nxt = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          nxt = '0;
          if (len_clamp != '0) begin
            state_nxt = RUN;
            valid_nxt = 1'b1;
          end else begin
            state_nxt = DONE;
          end
        end else begin
          state_nxt = IDLE;
        end
      end
      RUN: begin
        valid_nxt = 1'b1;
        if (fire) begin
          if (last) begin
            if (loop_q) begin
              nxt = '0;
            end else begin
              // Final entry accepted: cur holds, valid drops.
              valid_nxt = 1'b0;
              state_nxt = DONE;
            end
          end else begin
            nxt = cur + 1'b1;
          end
        end else begin
          nxt = cur;
        end
        // Abort wins over a simultaneous fire (which is still counted).
        if (abort) begin
          state_nxt = IDLE;
          valid_nxt = 1'b0;
        end else begin
          valid_nxt = valid_nxt;
        end
      end
      DONE: begin
        state_nxt = IDLE;
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  // Fields present the entry inst_gen will latch only when it will be valid.
  always_comb begin
    if (valid_nxt && !rst) begin
      field = rd_desc;
    end else begin
      field = '0;
    end
  end

  // State, index, run parameters and valid register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      cur        <= '0;
      len_q      <= '0;
      loop_q     <= 1'b0;
      inst_valid <= 1'b0;
    end else begin
      state      <= state_nxt;
      cur        <= nxt;
      inst_valid <= valid_nxt;
      if (state == IDLE && start) begin
        len_q  <= len_clamp;
        loop_q <= loop;
      end
    end
  end

  // Accepted-instruction counter, saturating.
  always_ff @(posedge clk) begin
    if (rst) begin
      issue_cnt <= 16'd0;
    end else if (state == IDLE && start) begin
      issue_cnt <= 16'd0;
    end else if (fire && issue_cnt != 16'hFFFF) begin
      issue_cnt <= issue_cnt + 16'd1;
    end
  end

  assign busy     = (state == RUN);
  assign done     = (state == DONE);
  assign inst_sel = field.inst_sel;
  assign func3    = field.func3;
  assign rs1      = field.rs1;
  assign rs2      = field.rs2;
  assign rd       = field.rd;
  assign immi     = field.imm[11:0];
  assign imms     = field.imm[11:0];
  assign immb     = field.imm[11:0];
  assign immu     = field.imm;
  assign immuj    = field.imm;

endmodule

// File: tb/tb_inst_seq_ctrl.sv
// Self-checking bench for inst_seq_ctrl. A local register stands in for
// inst_gen's registered inst; the model tracks which entry should be there.
module tb_inst_seq_ctrl;
  import inst_seq_pkg::*;

  logic        clk = 1'b0;
  logic        rst, wr_en, start, loop, abort, cpu_ready;
  logic [3:0]  wr_addr;
  logic [41:0] wr_data;
  logic [4:0]  len;
  logic [3:0]  inst_sel;
  logic [2:0]  func3;
  logic [4:0]  rs1, rs2, rd;
  logic [11:0] immi, imms, immb;
  logic [19:0] immu, immuj;
  logic        inst_valid, busy, done;
  logic [15:0] issue_cnt;

  int total = 0;
  int bad   = 0;
  desc_t model [16];
  desc_t inst_q;

  inst_seq_ctrl #(.DEPTH(16), .AW(4)) dut (
    .clk(clk), .rst(rst), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .start(start), .len(len), .loop(loop), .abort(abort), .cpu_ready(cpu_ready),
    .inst_sel(inst_sel), .func3(func3), .rs1(rs1), .rs2(rs2), .rd(rd),
    .immi(immi), .imms(imms), .immb(immb), .immu(immu), .immuj(immuj),
    .inst_valid(inst_valid), .busy(busy), .done(done), .issue_cnt(issue_cnt)
  );

  always #5 clk = ~clk;

  // Stand-in for inst_gen: registers whatever fields are presented.
  always @(posedge clk) inst_q <= {inst_sel, func3, rs1, rs2, rd, immu};

  task automatic load(input int a, input desc_t d);
    @(negedge clk);
    wr_en = 1'b1; wr_addr = 4'(a); wr_data = d;
    model[a] = d;
    @(negedge clk);
    wr_en = 1'b0;
  endtask

  function automatic desc_t mk(input logic [3:0] s, input logic [4:0] d_rd,
                               input logic [4:0] d_rs1, input logic [4:0] d_rs2,
                               input logic [19:0] im);
    desc_t d;
    d = '0;
    d.inst_sel = s; d.rd = d_rd; d.rs1 = d_rs1; d.rs2 = d_rs2; d.imm = im;
    return d;
  endfunction

  // mode: 0 always ready, 1 random ready, 2 stall 4 cycles on entry 1.
  // abort_at / rst_at: fire count at which to abort / reset (-1 = never).
  task automatic run_prog(input int n, input bit lp, input int mode,
                          input int abort_at, input bit wr_mid, input int rst_at);
    int eff, idx, fires, cyc, stall;
    bit fin, rdy;
    eff = (n > 16) ? 16 : n;
    @(negedge clk);
    start = 1'b1; len = 5'(n); loop = lp;
    @(negedge clk);
    start = 1'b0;
    if (eff == 0) begin
      total++;
      if (done !== 1'b1 || inst_valid !== 1'b0 || busy !== 1'b0) begin
        bad++; $display("FAIL len0_done: done=%b valid=%b busy=%b want 1 0 0", done, inst_valid, busy);
      end
      @(negedge clk);
      total++;
      if (done !== 1'b0 || inst_valid !== 1'b0 || issue_cnt !== 16'd0) begin
        bad++; $display("FAIL len0_after: done=%b valid=%b cnt=%0d want 0 0 0", done, inst_valid, issue_cnt);
      end
      return;
    end
    idx = 0; fires = 0; fin = 1'b0; cyc = 0; stall = 0;
    while (!fin && cyc < 600) begin
      total++;
      if (inst_valid !== 1'b1 || busy !== 1'b1 || done !== 1'b0) begin
        bad++; $display("FAIL run_flags: valid=%b busy=%b done=%b want 1 1 0", inst_valid, busy, done);
      end
      total++;
      if (inst_q !== model[idx]) begin
        bad++; $display("FAIL inst_entry: got %h want entry %0d = %h", inst_q, idx, model[idx]);
      end
      total++;
      if (inst_valid && (immi !== immu[11:0] || imms !== immu[11:0] || immb !== immu[11:0] || immuj !== immu)) begin
        bad++; $display("FAIL imm_fanout: i=%h s=%h b=%h u=%h uj=%h", immi, imms, immb, immu, immuj);
      end
      total++;
      if (issue_cnt !== 16'(fires)) begin
        bad++; $display("FAIL issue_cnt_run: got %0d want %0d", issue_cnt, fires);
      end
      wr_en = 1'b0;
      if (wr_mid && cyc == 0) begin
        wr_en = 1'b1; wr_addr = 4'd1; wr_data = {$urandom, $urandom};
      end
      if (rst_at >= 0 && fires == rst_at) begin
        rst = 1'b1; cpu_ready = 1'b1;
        @(negedge clk);
        total++;
        if (inst_valid !== 1'b0 || busy !== 1'b0 || done !== 1'b0 || issue_cnt !== 16'd0 ||
            {inst_sel, func3, rs1, rs2, rd, immi, imms, immb, immu, immuj} !== '0) begin
          bad++; $display("FAIL mid_reset: valid=%b busy=%b done=%b cnt=%0d sel=%h want all 0",
                          inst_valid, busy, done, issue_cnt, inst_sel);
        end
        rst = 1'b0; cpu_ready = 1'b0;
        return;
      end
      if (abort_at >= 0 && fires == abort_at) begin
        rdy = 1'($urandom_range(0, 1));
        abort = 1'b1; cpu_ready = rdy;
        @(negedge clk);
        abort = 1'b0; cpu_ready = 1'b0;
        fires += int'(rdy);
        total++;
        if (inst_valid !== 1'b0 || busy !== 1'b0 || done !== 1'b0 || issue_cnt !== 16'(fires)) begin
          bad++; $display("FAIL abort: valid=%b busy=%b done=%b cnt=%0d want 0 0 0 %0d",
                          inst_valid, busy, done, issue_cnt, fires);
        end
        @(negedge clk);
        total++;
        if (done !== 1'b0 || inst_valid !== 1'b0) begin
          bad++; $display("FAIL abort_nodone: done=%b valid=%b want 0 0", done, inst_valid);
        end
        return;
      end
      case (mode)
        0: rdy = 1'b1;
        1: rdy = 1'($urandom_range(0, 1));
        default: begin
          if (idx == 1 && stall < 4) begin rdy = 1'b0; stall++; end
          else rdy = 1'b1;
        end
      endcase
      cpu_ready = rdy;
      if (rdy) begin
        fires++;
        if (idx == eff - 1) begin
          if (lp) idx = 0; else fin = 1'b1;
        end else begin
          idx++;
        end
      end
      @(negedge clk);
      cyc++;
    end
    cpu_ready = 1'b0;
    wr_en = 1'b0;
    total++;
    if (!fin) begin
      bad++; $display("FAIL run_timeout: fires=%0d of %0d", fires, eff);
      return;
    end
    if (inst_valid !== 1'b0 || done !== 1'b1 || busy !== 1'b0 || issue_cnt !== 16'(fires)) begin
      bad++; $display("FAIL completion: valid=%b done=%b busy=%b cnt=%0d want 0 1 0 %0d",
                      inst_valid, done, busy, issue_cnt, fires);
    end
    @(negedge clk);
    total++;
    if (done !== 1'b0 || busy !== 1'b0 || inst_valid !== 1'b0 || inst_sel !== 4'd0) begin
      bad++; $display("FAIL back_idle: done=%b busy=%b valid=%b sel=%h", done, busy, inst_valid, inst_sel);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; wr_en = 1'b0; wr_addr = 4'd0; wr_data = 42'd0; start = 1'b0;
    len = 5'd0; loop = 1'b0; abort = 1'b0; cpu_ready = 1'b0;
    repeat (2) @(negedge clk);
    total++;
    if (inst_valid !== 1'b0 || busy !== 1'b0 || done !== 1'b0 || issue_cnt !== 16'd0 ||
        {inst_sel, func3, rs1, rs2, rd, immu} !== '0) begin
      bad++; $display("FAIL reset_state: valid=%b busy=%b done=%b cnt=%0d sel=%h", inst_valid, busy, done, issue_cnt, inst_sel);
    end
    rst = 1'b0;
    for (int i = 0; i < 16; i++) load(i, {$urandom, $urandom});
  endtask

  task automatic test_basic();
    load(0, mk(SEL_R1, 5'd1, 5'd2, 5'd3, 20'h0));
    load(1, mk(SEL_I, 5'd0, 5'd0, 5'd0, 20'h005));
    load(2, mk(SEL_U, 5'd0, 5'd0, 5'd0, 20'h12345));
    run_prog(3, 1'b0, 0, -1, 1'b0, -1);
  endtask

  task automatic test_stall();
    run_prog(3, 1'b0, 2, -1, 1'b0, -1);
  endtask

  task automatic test_loop_abort();
    run_prog(2, 1'b1, 0, 7, 1'b0, -1);
  endtask

  task automatic test_len_bounds();
    run_prog(0, 1'b0, 0, -1, 1'b0, -1);
    run_prog(20, 1'b0, 0, -1, 1'b0, -1);
    run_prog(16, 1'b0, 1, -1, 1'b0, -1);
  endtask

  task automatic test_write_busy();
    run_prog(4, 1'b0, 0, -1, 1'b1, -1);
  endtask

  task automatic test_mid_reset();
    run_prog(5, 1'b0, 0, -1, 1'b0, 2);
    run_prog(5, 1'b0, 0, -1, 1'b0, -1);
  endtask

  task automatic test_random();
    for (int k = 0; k < 8; k++) begin
      load($urandom_range(0, 15), {$urandom, $urandom});
      run_prog($urandom_range(1, 16), 1'($urandom_range(0, 1)), 1,
               $urandom_range(0, 20), 1'b0, -1);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_stall();
    test_loop_abort();
    test_len_bounds();
    test_write_busy();
    test_mid_reset();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
